md_unit_ctrl: RTL
=================

// Module: md_unit_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer with HI/LO registers for the pipelined MIPS CPU, E stage.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage, counts out the fixed operation latency and raises busy.
//  Commits results to HI/LO and serves MFHI/MFLO reads.
//  Drives the stall request the hazard unit uses to freeze D when an MD-class instruction would collide.
// PARAMETERS
//  MUL_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES  10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   synchronous, active-high; clears all state
//  start      in   1   E-stage instruction is an MD op this cycle
//  md_op      in   3   op code (package constants below); sampled only when start=1
//  rs_val     in   32  forwarded rs operand (E stage)
//  rt_val     in   32  forwarded rt operand (E stage)
//  rd_hi      in   1   1: md_rdata=HI, 0: md_rdata=LO (MFHI/MFLO)
//  md_use_d   in   1   D-stage instruction is MD-class (mult/div/mt*/mf*)
//  busy       out  1   operation in progress
//  md_stall   out  1   = (busy | (start & md_op is MULT/MULTU/DIV/DIVU)) & md_use_d
//  md_rdata   out  32  selected HI/LO, combinational from registers
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  - Reset: busy=0, hi=0, lo=0, counter=0, FSM=IDLE, latched operands/op=0; md_stall=0 unless start/md_use_d are driven.
//  - FSM IDLE/RUN. IDLE + start + MULT/MULTU/DIV/DIVU @edge t:
//    - Latch rs_val, rt_val and op; go RUN; cnt = N-1 (N = MUL_CYCLES or DIV_CYCLES).
//    - busy=1 during cycles t+1..t+N.
//    - At edge t+N: commit HI/LO, cnt==0 -> IDLE; busy=0 and new hi/lo visible from cycle t+N+1.
//  - RUN: cnt decrements each cycle; hi/lo hold old values until commit.
//  - MTHI/MTLO in IDLE: hi<=rs_val / lo<=rs_val at the same edge, single cycle, busy stays 0.
//  - start while busy=1: ignored, state unchanged. The hazard unit guarantees this never happens; the bench asserts it.
//  - start with md_op=MD_NONE or undefined code: no effect.
//  - Arithmetic on latched operands:
//    - MULT: {hi,lo} = signed 64-bit product. MULTU: unsigned 64-bit product.
//    - DIV: lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
//    - DIVU: unsigned quotient/remainder.
//    - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//    - Divisor 0 (DIV/DIVU): full busy period runs, hi/lo unchanged at commit.
//  - reset mid-RUN: the operation is aborted; everything returns to reset values on that edge.
//  - Simultaneous commit edge and new start is impossible (busy=1 then); MF read in the commit cycle returns the old value.
//  - md_stall is purely combinational: no added latency; D is held every cycle it is high.
// STRUCTURE
//  - Shared package (mips_defs): MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6;
//    FSM state encodings MD_IDLE=0, MD_RUN=1.
//  - Sub-module md_arith: combinational, {op, a, b} -> {hi_res, lo_res, div0}.
//  - This block holds only the FSM, counter, operand latches, HI/LO and the stall logic.
// TESTING
//  - MULT rs=0xFFFFFFFE, rt=3 @t -> busy 1 for 5 cycles; from t+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at t+6.
//  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at t+11; DIVU 7/0 -> busy 10 cycles, hi/lo unchanged.
//  - MTHI 0x1234 then MFHI (rd_hi=1) next cycle -> md_rdata=0x00001234, busy never 1.
//  - DIV started, md_use_d=1 -> md_stall=1 in start cycle and all 10 busy cycles, 0 at t+11.
//  - reset asserted at 3rd busy cycle of MULT -> next cycle busy=0, hi=lo=0; a new MULT then completes normally.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MD-unit definitions: op codes, FSM state encoding and op classification helpers.
package mips_defs;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing HI/LO results for one MD op.
module md_arith
  import mips_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div0
);

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q_div, r_div;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes; the 0x80000000/-1 case wraps back to 0x80000000.
    a_neg  = (op == MD_DIV) && a[31];
    b_neg  = (op == MD_DIV) && b[31];
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    q_div  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_div  = a_neg ? (32'd0 - r_mag) : r_mag;

    div0   = md_is_div(op) && (b == 32'd0);

    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MD_MULT:         {hi_res, lo_res} = prod_s;
      MD_MULTU:        {hi_res, lo_res} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi_res = r_div;
        lo_res = q_div;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// MD sequencer: counts out fixed mult/div latency, commits HI/LO, serves MF reads, drives D-stage stall.
module md_unit_ctrl
  import mips_defs::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  input  logic        md_use_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] md_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_res, lo_res;
  logic             div0;

  md_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          if (md_is_arith(md_op)) begin
            state_d = MD_RUN;
            op_d    = md_op;
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = md_is_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      MD_RUN: begin
        // Starts arriving while running are dropped; the hazard unit prevents them.
        if (cnt_q == '0) begin
          state_d = MD_IDLE;
          if (!div0) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == MD_RUN);
  assign md_stall = (busy | (start & md_is_arith(md_op))) & md_use_d;
  assign md_rdata = rd_hi ? hi_q : lo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
